// File: rtl/life_pkg.sv
// life_pkg: shared types and constants for the Game of Life controller.
//   state_t  - controller FSM state, 3-bit encoding
//   owner_t  - which requester currently owns the arena row-write port
//   ROW_W    - width of the arena row-select bus
//   owner_of - maps a controller state to the arena port owner
package life_pkg;

  localparam int ROW_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEED_REQ  = 3'd1,
    SEED_WAIT = 3'd2,
    STEP_REQ  = 3'd3,
    STEP_WAIT = 3'd4,
    RUN_WAIT  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_SEEDER = 2'd1,
    OWN_ENGINE = 2'd2
  } owner_t;

  // The seeder owns the arena for the whole seeding phase, the engine for
  // the whole stepping phase; nobody owns it otherwise.
  function automatic owner_t owner_of(input state_t s);
    case (s)
      SEED_REQ, SEED_WAIT: owner_of = OWN_SEEDER;
      STEP_REQ, STEP_WAIT: owner_of = OWN_ENGINE;
      default:             owner_of = OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/arena_port_mux.sv
// arena_port_mux: combinational 2-requester mux for the single arena
// row-write port.
// Ports:
//   owner_i                  - current owner (OWN_NONE/OWN_SEEDER/OWN_ENGINE)
//   seeder_row_i/cols_i/write_i - seeder request
//   engine_row_i/cols_i/write_i - engine request
//   row_o/cols_o/write_o     - arena port; all zero when nobody owns it
module arena_port_mux
  import life_pkg::*;
#(
  parameter int COL_W = 10
) (
  input  owner_t             owner_i,
  input  logic [ROW_W-1:0]   seeder_row_i,
  input  logic [COL_W-1:0]   seeder_cols_i,
  input  logic               seeder_write_i,
  input  logic [ROW_W-1:0]   engine_row_i,
  input  logic [COL_W-1:0]   engine_cols_i,
  input  logic               engine_write_i,
  output logic [ROW_W-1:0]   row_o,
  output logic [COL_W-1:0]   cols_o,
  output logic               write_o
);

  // A non-owning requester is fully masked, so its write strobe can never
  // reach the arena.
  always_comb begin
    row_o   = '0;
    cols_o  = '0;
    write_o = 1'b0;
    case (owner_i)
      OWN_SEEDER: begin
        row_o   = seeder_row_i;
        cols_o  = seeder_cols_i;
        write_o = seeder_write_i;
      end
      OWN_ENGINE: begin
        row_o   = engine_row_i;
        cols_o  = engine_cols_i;
        write_o = engine_write_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/life_controller.sv
// life_controller: top-level sequencer for the Game of Life core.
// Takes user commands (seed/run/pause/step), drives the seeder and the
// generation engine through start/ready handshakes, paces free-run
// generations with an external tick, and owns the arena row-write port.
//
// Handshake: the controller raises *_start for exactly one cycle (the REQ
// state). The slave answers by dropping *_ready one cycle after start and
// raising it again when done; ready is only looked at in the WAIT state.
//
// Ports:
//   clk, reset (async, active-high)
//   cmd_seed/cmd_run/cmd_pause/cmd_step - one-cycle command pulses
//   seed_value - seed word latched when cmd_seed is accepted
//   tick       - free-run pacing strobe
//   seeder_*   - seeder handshake and row-write request
//   engine_*   - engine handshake and row-write request
//   arena_*    - muxed arena row-write port
//   running    - free-run mode active
//   busy       - seeding or stepping in progress
//   generation - generations computed since the last seed
//   tick_overruns - (only with LIFE_CTRL_OVERRUN_CNT_EN) saturating count of
//                   ticks dropped while stepping in free-run
//   state_dbg  - current FSM state, for observation
// Optional build macro: LIFE_CTRL_OVERRUN_CNT_EN
module life_controller
  import life_pkg::*;
#(
  parameter int ARENA_WIDTH = 10,
  parameter int GEN_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_seed,
  input  logic                   cmd_run,
  input  logic                   cmd_pause,
  input  logic                   cmd_step,
  input  logic [31:0]            seed_value,
  input  logic                   tick,
  output logic                   seeder_start,
  output logic [31:0]            seeder_seed,
  input  logic                   seeder_ready,
  input  logic [ROW_W-1:0]       seeder_row,
  input  logic [ARENA_WIDTH-1:0] seeder_cols,
  input  logic                   seeder_write,
  output logic                   engine_start,
  input  logic                   engine_ready,
  input  logic [ROW_W-1:0]       engine_row,
  input  logic [ARENA_WIDTH-1:0] engine_cols,
  input  logic                   engine_write,
  output logic [ROW_W-1:0]       arena_row_select,
  output logic [ARENA_WIDTH-1:0] arena_columns_new,
  output logic                   arena_columns_write,
  output logic                   running,
  output logic                   busy,
  output logic [GEN_WIDTH-1:0]   generation,
`ifdef LIFE_CTRL_OVERRUN_CNT_EN
  output logic [7:0]             tick_overruns,
`endif
  output state_t                 state_dbg
);

  state_t               state_q;
  logic                 run_mode_q;
  logic                 pause_pending_q;
  logic [31:0]          seed_q;
  logic [GEN_WIDTH-1:0] gen_q;
  logic                 seeder_start_q;
  logic                 engine_start_q;
  logic                 in_step;
  logic                 pause_eff;

  assign in_step = (state_q == STEP_REQ) || (state_q == STEP_WAIT);

  // A pause arriving in the very cycle the step completes is honoured just
  // like one that arrived earlier in the step.
  assign pause_eff = pause_pending_q | (cmd_pause & run_mode_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      run_mode_q      <= 1'b0;
      pause_pending_q <= 1'b0;
      seed_q          <= '0;
      gen_q           <= '0;
      seeder_start_q  <= 1'b0;
      engine_start_q  <= 1'b0;
    end else begin
      seeder_start_q <= 1'b0;
      engine_start_q <= 1'b0;

      // While busy, a pause is only remembered when free-run is active.
      if (state_q != IDLE && state_q != RUN_WAIT && cmd_pause && run_mode_q) begin
        pause_pending_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (cmd_seed) begin
            seed_q         <= seed_value;
            run_mode_q     <= 1'b0;
            seeder_start_q <= 1'b1;
            state_q        <= SEED_REQ;
          end else if (cmd_step) begin
            engine_start_q <= 1'b1;
            state_q        <= STEP_REQ;
          end else if (cmd_run) begin
            run_mode_q <= 1'b1;
            state_q    <= RUN_WAIT;
          end
        end
        RUN_WAIT: begin
          // cmd_step and cmd_run are meaningless here; pause beats tick.
          if (cmd_seed) begin
            seed_q         <= seed_value;
            run_mode_q     <= 1'b0;
            seeder_start_q <= 1'b1;
            state_q        <= SEED_REQ;
          end else if (cmd_pause) begin
            run_mode_q <= 1'b0;
            state_q    <= IDLE;
          end else if (tick) begin
            engine_start_q <= 1'b1;
            state_q        <= STEP_REQ;
          end
        end
        SEED_REQ:  state_q <= SEED_WAIT;
        SEED_WAIT: begin
          if (seeder_ready) begin
            gen_q   <= '0;
            state_q <= IDLE;
          end
        end
        STEP_REQ:  state_q <= STEP_WAIT;
        STEP_WAIT: begin
          if (engine_ready) begin
            gen_q           <= gen_q + {{(GEN_WIDTH-1){1'b0}}, 1'b1};
            pause_pending_q <= 1'b0;
            if (pause_eff) begin
              run_mode_q <= 1'b0;
            end
            state_q <= (run_mode_q && !pause_eff) ? RUN_WAIT : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef LIFE_CTRL_OVERRUN_CNT_EN
  logic [7:0] overrun_q;
  logic [7:0] overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (state_q == SEED_WAIT && seeder_ready) begin
      overrun_d = 8'd0;
    end else if (tick && run_mode_q && in_step && overrun_q != 8'hFF) begin
      overrun_d = overrun_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q <= 8'd0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign tick_overruns = overrun_q;
`endif

  arena_port_mux #(
    .COL_W (ARENA_WIDTH)
  ) u_mux (
    .owner_i        (owner_of(state_q)),
    .seeder_row_i   (seeder_row),
    .seeder_cols_i  (seeder_cols),
    .seeder_write_i (seeder_write),
    .engine_row_i   (engine_row),
    .engine_cols_i  (engine_cols),
    .engine_write_i (engine_write),
    .row_o          (arena_row_select),
    .cols_o         (arena_columns_new),
    .write_o        (arena_columns_write)
  );

  assign seeder_start = seeder_start_q;
  assign seeder_seed  = seed_q;
  assign engine_start = engine_start_q;
  assign running      = run_mode_q;
  assign busy         = (state_q == SEED_REQ) || (state_q == SEED_WAIT) || in_step;
  assign generation   = gen_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_life_controller.sv
// Bench for life_controller: directed sequences plus a table of arena-mux
// vectors, with behavioural seeder/engine responders.
module tb_life_controller;
  import life_pkg::*;

  localparam int AW = 10;
  localparam int GW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_seed = 1'b0, cmd_run = 1'b0, cmd_pause = 1'b0, cmd_step = 1'b0;
  logic [31:0]   seed_value = '0;
  logic          tick = 1'b0;
  logic          seeder_start, engine_start;
  logic [31:0]   seeder_seed;
  logic          seeder_ready = 1'b1, engine_ready = 1'b1;
  logic [7:0]    seeder_row = '0, engine_row = '0;
  logic [AW-1:0] seeder_cols = '0, engine_cols = '0;
  logic          seeder_write = 1'b0, engine_write = 1'b0;
  logic [7:0]    arena_row_select;
  logic [AW-1:0] arena_columns_new;
  logic          arena_columns_write;
  logic          running, busy;
  logic [GW-1:0] generation;
  state_t        state_dbg;
`ifdef LIFE_CTRL_OVERRUN_CNT_EN
  logic [7:0]    tick_overruns;
`endif

  life_controller #(.ARENA_WIDTH(AW), .GEN_WIDTH(GW)) dut (
    .clk(clk), .reset(reset),
    .cmd_seed(cmd_seed), .cmd_run(cmd_run), .cmd_pause(cmd_pause), .cmd_step(cmd_step),
    .seed_value(seed_value), .tick(tick),
    .seeder_start(seeder_start), .seeder_seed(seeder_seed), .seeder_ready(seeder_ready),
    .seeder_row(seeder_row), .seeder_cols(seeder_cols), .seeder_write(seeder_write),
    .engine_start(engine_start), .engine_ready(engine_ready),
    .engine_row(engine_row), .engine_cols(engine_cols), .engine_write(engine_write),
    .arena_row_select(arena_row_select), .arena_columns_new(arena_columns_new),
    .arena_columns_write(arena_columns_write),
    .running(running), .busy(busy), .generation(generation),
`ifdef LIFE_CTRL_OVERRUN_CNT_EN
    .tick_overruns(tick_overruns),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- slave responders ----------------
  // Each counts start cycles, drops ready right after start and raises it
  // again after the configured number of cycles.
  int seed_lat = 5, eng_lat = 8;
  int seed_cnt = 0, eng_cnt = 0;
  int seed_starts = 0, eng_starts = 0;

  always @(negedge clk) begin
    if (reset) begin
      seeder_ready = 1'b1;
      seed_cnt = 0;
    end else if (seeder_start) begin
      seed_starts++;
      seeder_ready = 1'b0;
      seed_cnt = seed_lat;
    end else if (!seeder_ready) begin
      seed_cnt--;
      if (seed_cnt <= 0) seeder_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      engine_ready = 1'b1;
      eng_cnt = 0;
    end else if (engine_start) begin
      eng_starts++;
      engine_ready = 1'b0;
      eng_cnt = eng_lat;
    end else if (!engine_ready) begin
      eng_cnt--;
      if (eng_cnt <= 0) engine_ready = 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  int exp_gen = 0;
  logic [GW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_seed(input logic [31:0] v);
    @(negedge clk); seed_value = v; cmd_seed = 1'b1;
    @(negedge clk); cmd_seed = 1'b0;
  endtask
  task automatic pulse_step();
    @(negedge clk); cmd_step = 1'b1;
    @(negedge clk); cmd_step = 1'b0;
  endtask
  task automatic pulse_run();
    @(negedge clk); cmd_run = 1'b1;
    @(negedge clk); cmd_run = 1'b0;
  endtask
  task automatic pulse_pause();
    @(negedge clk); cmd_pause = 1'b1;
    @(negedge clk); cmd_pause = 1'b0;
  endtask
  task automatic pulse_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, " idle in time"}, 64'(busy), 64'(0));
  endtask

  // ---------------- arena mux vector table ----------------
  // phase 0: IDLE, 1: seeding, 2: stepping
  typedef struct {
    int            phase;
    logic [7:0]    s_row;
    logic [AW-1:0] s_cols;
    logic          s_wr;
    logic [7:0]    e_row;
    logic [AW-1:0] e_cols;
    logic          e_wr;
    logic [7:0]    x_row;
    logic [AW-1:0] x_cols;
    logic          x_wr;
  } vec_t;
  vec_t vecs[8];

  task automatic apply_vecs(input int ph);
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].phase == ph) begin
        seeder_row = vecs[i].s_row; seeder_cols = vecs[i].s_cols; seeder_write = vecs[i].s_wr;
        engine_row = vecs[i].e_row; engine_cols = vecs[i].e_cols; engine_write = vecs[i].e_wr;
        #1;
        check($sformatf("mux v%0d", i),
              64'({arena_row_select, arena_columns_new, arena_columns_write}),
              64'({vecs[i].x_row, vecs[i].x_cols, vecs[i].x_wr}));
        @(negedge clk);
      end
    end
    seeder_row = '0; seeder_cols = '0; seeder_write = 1'b0;
    engine_row = '0; engine_cols = '0; engine_write = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  int s0, e0, n;

  initial begin
    vecs[0] = '{0, 8'd3,   10'h155, 1'b1, 8'd7,   10'h2AA, 1'b1, 8'd0,   10'h000, 1'b0};
    vecs[1] = '{0, 8'hFF,  10'h3FF, 1'b1, 8'd0,   10'h000, 1'b0, 8'd0,   10'h000, 1'b0};
    vecs[2] = '{1, 8'd5,   10'h155, 1'b1, 8'd9,   10'h2AA, 1'b1, 8'd5,   10'h155, 1'b1};
    vecs[3] = '{1, 8'hFF,  10'h3FF, 1'b0, 8'd1,   10'h001, 1'b1, 8'hFF,  10'h3FF, 1'b0};
    vecs[4] = '{1, 8'd0,   10'h000, 1'b1, 8'hAA,  10'h0F0, 1'b0, 8'd0,   10'h000, 1'b1};
    vecs[5] = '{2, 8'd5,   10'h155, 1'b1, 8'd9,   10'h2AA, 1'b1, 8'd9,   10'h2AA, 1'b1};
    vecs[6] = '{2, 8'd1,   10'h3FF, 1'b1, 8'h80,  10'h000, 1'b0, 8'h80,  10'h000, 1'b0};
    vecs[7] = '{2, 8'd0,   10'h000, 1'b0, 8'hFF,  10'h3FF, 1'b1, 8'hFF,  10'h3FF, 1'b1};

    // Reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset ctl outs",
          64'({seeder_start, engine_start, arena_row_select, arena_columns_new,
               arena_columns_write, running, busy, generation}), 64'(0));
    check("reset seed", 64'(seeder_seed), 64'(0));
    check("reset state", 64'(state_dbg), 64'(IDLE));
`ifdef LIFE_CTRL_OVERRUN_CNT_EN
    check("reset overruns", 64'(tick_overruns), 64'(0));
`endif
    reset = 1'b0;
    @(negedge clk);

    // Seed: ready low 5 cycles after start
    seed_lat = 5;
    s0 = seed_starts;
    pulse_seed(32'hDEADBEEF);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("seed busy cycles", 64'(n), 64'(seed_lat + 1));
    check("seed word", 64'(seeder_seed), 64'(32'hDEADBEEF));
    check("seed start pulses", 64'(seed_starts - s0), 64'(1));
    check("seed gen", 64'(generation), 64'(0));
    check("seed state", 64'(state_dbg), 64'(IDLE));
    apply_vecs(0);

    // Three single steps
    eng_lat = 8;
    e0 = eng_starts;
    for (int k = 0; k < 3; k++) begin
      pulse_step();
      check("step running", 64'(running), 64'(0));
      wait_idle(50, "step");
      exp_gen++;
      exp_q.push_back(GW'(exp_gen));
    end
    check("step starts", 64'(eng_starts - e0), 64'(3));
    while (exp_q.size() > 1) void'(exp_q.pop_front());
    check("step gen", 64'(generation), 64'(exp_q.pop_front()));

    // Reseed with long latency; exercise mux while seeder owns the port
    seed_lat = 20;
    pulse_seed(32'h00000A5A);
    apply_vecs(1);
    wait_idle(40, "reseed");
    exp_gen = 0;
    check("reseed clears gen", 64'(generation), 64'(exp_gen));

    // Free-run: 4 ticks 20 cycles apart
    eng_lat = 8;
    e0 = eng_starts;
    pulse_run();
    check("run running", 64'(running), 64'(1));
    check("run state", 64'(state_dbg), 64'(RUN_WAIT));
    for (int k = 0; k < 4; k++) begin
      pulse_tick();
      repeat (19) @(negedge clk);
      exp_gen++;
    end
    check("run gen", 64'(generation), 64'(exp_gen));
    check("run starts", 64'(eng_starts - e0), 64'(4));
    check("run state after ticks", 64'(state_dbg), 64'(RUN_WAIT));
    @(negedge clk); cmd_pause = 1'b1;
    check("pause pre running", 64'(running), 64'(1));
    @(negedge clk); cmd_pause = 1'b0;
    check("pause running", 64'(running), 64'(0));
    check("pause state", 64'(state_dbg), 64'(IDLE));

    // Pause mid-step
    pulse_run();
    pulse_tick();
    repeat (3) @(negedge clk);
    check("midstep state", 64'(state_dbg), 64'(STEP_WAIT));
    pulse_pause();
    check("midstep running held", 64'(running), 64'(1));
    wait_idle(50, "midstep");
    exp_gen++;
    check("midstep gen", 64'(generation), 64'(exp_gen));
    check("midstep running", 64'(running), 64'(0));
    check("midstep state idle", 64'(state_dbg), 64'(IDLE));
    e0 = eng_starts;
    pulse_tick();
    repeat (5) @(negedge clk);
    pulse_tick();
    repeat (5) @(negedge clk);
    check("midstep no restart", 64'(eng_starts - e0), 64'(0));

    // Dropped commands and tick overruns during one long step
    eng_lat = 400;
    pulse_run();
    e0 = eng_starts;
    s0 = seed_starts;
    pulse_tick();
    repeat (3) pulse_tick();
`ifdef LIFE_CTRL_OVERRUN_CNT_EN
    check("overruns 3", 64'(tick_overruns), 64'(3));
`endif
    @(negedge clk); tick = 1'b1;
    for (int i = 0; i < 297; i++) begin
      if (i == 100) begin seed_value = 32'hFFFF0000; cmd_seed = 1'b1; end
      if (i == 101) cmd_seed = 1'b0;
      if (i == 150) cmd_step = 1'b1;
      if (i == 151) cmd_step = 1'b0;
      if (i == 200) cmd_run = 1'b1;
      if (i == 201) cmd_run = 1'b0;
      @(negedge clk);
    end
    tick = 1'b0;
    check("drop seed word", 64'(seeder_seed), 64'(32'h00000A5A));
    check("drop still stepping", 64'(state_dbg), 64'(STEP_WAIT));
    wait_idle(200, "drop");
    exp_gen++;
    check("drop gen", 64'(generation), 64'(exp_gen));
    check("drop engine starts", 64'(eng_starts - e0), 64'(1));
    check("drop seeder starts", 64'(seed_starts - s0), 64'(0));
    check("drop state", 64'(state_dbg), 64'(RUN_WAIT));
`ifdef LIFE_CTRL_OVERRUN_CNT_EN
    check("overruns sat", 64'(tick_overruns), 64'(255));
`endif
    pulse_pause();
    check("drop pause state", 64'(state_dbg), 64'(IDLE));

    // Mux while the engine owns the port
    eng_lat = 20;
    pulse_step();
    apply_vecs(2);
    wait_idle(40, "mux step");

    // Seed completion clears generation and overruns
    seed_lat = 5;
    pulse_seed(32'h0BADF00D);
    wait_idle(40, "seed clr");
    check("seed clr gen", 64'(generation), 64'(0));
`ifdef LIFE_CTRL_OVERRUN_CNT_EN
    check("seed clr overruns", 64'(tick_overruns), 64'(0));
`endif

    // Reset during SEED_WAIT
    seed_lat = 10;
    pulse_seed(32'h12345678);
    @(negedge clk);
    seeder_row = 8'h33; seeder_cols = 10'h3FF; seeder_write = 1'b1;
    #1;
    check("pre-reset state", 64'(state_dbg), 64'(SEED_WAIT));
    check("pre-reset arena", 64'({arena_row_select, arena_columns_write}), 64'({8'h33, 1'b1}));
    reset = 1'b1;
    #1;
    check("mid reset ctl outs",
          64'({seeder_start, engine_start, arena_row_select, arena_columns_new,
               arena_columns_write, running, busy, generation}), 64'(0));
    check("mid reset seed", 64'(seeder_seed), 64'(0));
    check("mid reset state", 64'(state_dbg), 64'(IDLE));
    seeder_row = '0; seeder_cols = '0; seeder_write = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    s0 = seed_starts;
    seed_lat = 5;
    pulse_seed(32'hCAFEF00D);
    wait_idle(40, "post-reset seed");
    check("post-reset seed word", 64'(seeder_seed), 64'(32'hCAFEF00D));
    check("post-reset seed starts", 64'(seed_starts - s0), 64'(1));
    check("post-reset gen", 64'(generation), 64'(0));
    check("post-reset state", 64'(state_dbg), 64'(IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/life_controller.md
Name: life_controller

Overview:
- Top-level sequencer for the Game of Life core.
- Accepts user commands (seed, run, pause, single-step) and drives the seeder and the generation engine through their start/ready handshakes.
- Paces free-running generations with an external tick strobe.
- Owns the single arena row-write port and multiplexes it between the seeder and the engine.

Parameters:
- ARENA_WIDTH, 10, arena columns; width of the column data buses.
- GEN_WIDTH, 16, width of the generation counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- cmd_seed  in  1  one-cycle pulse: reseed the arena with seed_value.
- cmd_run  in  1  one-cycle pulse: enter free-run mode.
- cmd_pause  in  1  one-cycle pulse: leave free-run mode.
- cmd_step  in  1  one-cycle pulse: compute exactly one generation.
- seed_value  in  32  seed word, sampled in the cycle cmd_seed is accepted.
- tick  in  1  one-cycle pacing strobe for free-run mode.
- seeder_start  out  1  start pulse to the seeder.
- seeder_seed  out  32  registered seed word to the seeder.
- seeder_ready  in  1  seeder idle.
- seeder_row  in  8  seeder arena row select.
- seeder_cols  in  ARENA_WIDTH  seeder row data.
- seeder_write  in  1  seeder row write strobe.
- engine_start  out  1  start pulse to the generation engine.
- engine_ready  in  1  engine idle.
- engine_row  in  8  engine arena row select.
- engine_cols  in  ARENA_WIDTH  engine row data.
- engine_write  in  1  engine row write strobe.
- arena_row_select  out  8  muxed row select.
- arena_columns_new  out  ARENA_WIDTH  muxed row data.
- arena_columns_write  out  1  muxed write strobe.
- running  out  1  free-run mode active, including a step in progress while in free-run.
- busy  out  1  seeding or stepping in progress.
- generation  out  GEN_WIDTH  generations computed since the last seed.

Behaviour:
- States: IDLE, SEED_REQ, SEED_WAIT, STEP_REQ, STEP_WAIT, RUN_WAIT. The free-run flag run_mode is held in a separate register.
- Reset values: state IDLE, run_mode 0, seeder_seed 0, generation 0, pause_pending 0.
- While reset is asserted, all outputs are 0 (the arena_* outputs included).
- Reset mid-operation aborts at once. No completion is reported and the counter is not updated.
- Command priority within one cycle: cmd_seed > cmd_step > cmd_run > cmd_pause.

Commands by state:
- IDLE:
  - cmd_seed: latch seed_value, go to SEED_REQ, clear run_mode.
  - cmd_step: go to STEP_REQ.
  - cmd_run: set run_mode, go to RUN_WAIT.
  - cmd_pause: ignored.
- RUN_WAIT:
  - tick: go to STEP_REQ.
  - cmd_pause: clear run_mode, go to IDLE.
  - cmd_seed: as in IDLE.
  - cmd_step and cmd_run: ignored.
- SEED_REQ and STEP_REQ:
  - Assert the matching *_start for exactly one cycle, then go to the matching *_WAIT state.
  - The slave's ready is not sampled in the REQ cycle. The slave drops ready one cycle after start.
- SEED_WAIT:
  - Leave when seeder_ready=1. Clear generation and go to IDLE.
  - The ready sample falls 2 cycles after start at the earliest.
- STEP_WAIT: when engine_ready=1:
  - Increment generation; it wraps from all-ones to 0.
  - Go to RUN_WAIT if run_mode=1 and pause_pending=0, otherwise to IDLE.
  - Clear pause_pending and, if it was set, also run_mode.

Commands while busy (SEED_*, STEP_*):
- cmd_seed, cmd_step and cmd_run are dropped.
- cmd_pause sets pause_pending only if run_mode=1; otherwise it is dropped.
- tick is dropped in every state except RUN_WAIT. There is no queueing.
- If tick and cmd_pause arrive in the same cycle in RUN_WAIT, the pause wins.

Arena mux:
- Purely combinational from the inputs, selected by the registered state.
- SEED_*: seeder_*. STEP_*: engine_*.
- All other states: row_select 0, columns 0, write 0.
- A write strobe from a non-owning requester never reaches the arena.

Status outputs:
- busy = state in {SEED_REQ, SEED_WAIT, STEP_REQ, STEP_WAIT}.
- running = run_mode.

Optional Feature:
- Macro: LIFE_CTRL_OVERRUN_CNT_EN.
- With the macro:
  - Extra output tick_overruns, 8 bits, reset 0.
  - Counts ticks dropped while run_mode=1 and state is STEP_*.
  - Saturates at 255 and clears on seed completion.
- Without the macro: the port and the logic are absent.

Decomposition:
- Package life_pkg holds:
  - the state enum, 3-bit encoding;
  - the requester-select enum {OWN_NONE, OWN_SEEDER, OWN_ENGINE};
  - the row-select width constant, 8.
- Sub-module arena_port_mux: a combinational 2-requester mux driven by the owner select.
- The FSM and counters stay in life_controller.

Test Plan:
- Seed:
  - Stimulus: cmd_seed with seed_value=32'hDEADBEEF; the seeder model holds ready low for 5 cycles after start.
  - Response: seeder_seed=DEADBEEF; exactly one seeder_start pulse; busy high throughout; generation=0 on return to IDLE; arena writes come only from the seeder.
- Step:
  - Stimulus: cmd_step from IDLE, three times in sequence.
  - Response: three engine_start pulses; generation=3; running stays 0; engine writes pass through, seeder writes are blocked.
- Free-run:
  - Stimulus: cmd_run, then 4 ticks spaced 20 cycles apart (the engine takes 8 cycles), then cmd_pause in RUN_WAIT.
  - Response: generation=4; running falls the cycle after the pause; state IDLE.
- Pause mid-step:
  - Stimulus: cmd_pause during STEP_WAIT in free-run.
  - Response: the step completes and generation increments by 1; then IDLE with running=0; no further engine_start on later ticks.
- Dropped commands and overrun:
  - Stimulus: tick and cmd_seed during STEP_WAIT; with LIFE_CTRL_OVERRUN_CNT_EN, 300 dropped ticks.
  - Response: no extra start pulses; tick_overruns=255.
- Reset:
  - Stimulus: reset asserted during SEED_WAIT.
  - Response: all outputs 0 immediately; state IDLE; generation unchanged from 0; a subsequent cmd_seed works normally.
